crc3_checker: RTL and testbench

Serial CRC-3 receiver/checker; the receive-side counterpart of the team's CRC-3 serial encoder. It accepts an 8-bit codeword, MSB-first: five message bits followed by three CRC bits. The remainder is recomputed with the same polynomial, x^3 + x + 1, and the same LFSR. After the eighth bit the block presents the recovered message together with a pass/fail verdict, and holds it until the stream is deasserted.

---
 rtl/crc3_checker.sv | 153 +++++++++++++++
 tb/tb_crc3_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/crc3_checker.sv
// +----------------------------------------------------------------------------+
// | crc3_checker                                                               |
// | Serial CRC-3 (x^3+x+1) receiver: 5 message bits + 3 CRC bits, MSB first.   |
// | Optional macro CRC3_ERRCNT_EN enables the saturating failed-codeword count.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module crc3_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       enable,
  input  logic       data_in,
  output logic [4:0] msg_out,
  output logic [2:0] crc_calc,
  output logic       done,
  output logic       crc_ok,
  output logic       crc_err,
  output logic [7:0] err_count
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RECV = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam logic [3:0] c_MSG_BITS = 4'd5;
  localparam logic [3:0] c_LAST_BIT = 4'd7;

  logic [1:0] state_q,    state_d;
  logic [3:0] bit_cnt_q,  bit_cnt_d;
  logic [4:0] msg_q,      msg_d;
  logic [2:0] lfsr_q,     lfsr_d;
  logic [2:0] rx_crc_q,   rx_crc_d;
  logic [4:0] msg_out_q,  msg_out_d;
  logic [2:0] crc_calc_q, crc_calc_d;
  logic       done_q,     done_d;
  logic       crc_ok_q,   crc_ok_d;
  logic       crc_err_q,  crc_err_d;

  logic       w_accept;
  logic       w_last;
  logic       w_lfsr_in;
  logic [2:0] w_lfsr_next;
  logic       w_match;

  assign w_accept    = ena && enable && (state_q != c_DONE);
  assign w_last      = w_accept && (bit_cnt_q == c_LAST_BIT);
  // CRC bits feed zeros into the LFSR; the received CRC is compared, not shifted in.
  assign w_lfsr_in   = (bit_cnt_q < c_MSG_BITS) ? data_in : 1'b0;
  assign w_lfsr_next = {w_lfsr_in ^ lfsr_q[2] ^ lfsr_q[0], lfsr_q[2:1]};
  assign w_match     = (w_lfsr_next == {rx_crc_q[1:0], data_in});

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    msg_d      = msg_q;
    lfsr_d     = lfsr_q;
    rx_crc_d   = rx_crc_q;
    msg_out_d  = msg_out_q;
    crc_calc_d = crc_calc_q;
    done_d     = done_q;
    crc_ok_d   = crc_ok_q;
    crc_err_d  = crc_err_q;

    if (ena && !enable) begin
      state_d    = c_IDLE;
      bit_cnt_d  = 4'd0;
      msg_d      = 5'd0;
      lfsr_d     = 3'd0;
      rx_crc_d   = 3'd0;
      msg_out_d  = 5'd0;
      crc_calc_d = 3'd0;
      done_d     = 1'b0;
      crc_ok_d   = 1'b0;
      crc_err_d  = 1'b0;
    end else if (w_accept) begin
      lfsr_d    = w_lfsr_next;
      bit_cnt_d = bit_cnt_q + 4'd1;
      state_d   = c_RECV;
      if (bit_cnt_q < c_MSG_BITS) begin
        msg_d = {msg_q[3:0], data_in};
      end else begin
        rx_crc_d = {rx_crc_q[1:0], data_in};
      end
      if (w_last) begin
        state_d    = c_DONE;
        msg_out_d  = msg_q;
        crc_calc_d = w_lfsr_next;
        done_d     = 1'b1;
        crc_ok_d   = w_match;
        crc_err_d  = !w_match;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= c_IDLE;
      bit_cnt_q  <= 4'd0;
      msg_q      <= 5'd0;
      lfsr_q     <= 3'd0;
      rx_crc_q   <= 3'd0;
      msg_out_q  <= 5'd0;
      crc_calc_q <= 3'd0;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      msg_q      <= msg_d;
      lfsr_q     <= lfsr_d;
      rx_crc_q   <= rx_crc_d;
      msg_out_q  <= msg_out_d;
      crc_calc_q <= crc_calc_d;
      done_q     <= done_d;
      crc_ok_q   <= crc_ok_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign msg_out  = msg_out_q;
  assign crc_calc = crc_calc_q;
  assign done     = done_q;
  assign crc_ok   = crc_ok_q;
  assign crc_err  = crc_err_q;

`ifdef CRC3_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (w_last && !w_match && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc3_checker.sv
// Self-checking bench for crc3_checker: fixed vectors, corner sequences and
// random codewords checked against a transaction-level reference model.
`default_nettype none

module tb_crc3_checker;

  logic       clk = 1'b0;
  logic       reset, ena, enable, data_in;
  logic [4:0] msg_out;
  logic [2:0] crc_calc;
  logic       done, crc_ok, crc_err;
  logic [7:0] err_count;

  crc3_checker dut (
    .clk(clk), .reset(reset), .ena(ena), .enable(enable), .data_in(data_in),
    .msg_out(msg_out), .crc_calc(crc_calc), .done(done), .crc_ok(crc_ok),
    .crc_err(crc_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

`ifdef CRC3_ERRCNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  typedef struct {
    logic [7:0] cw;
    logic [4:0] msg;
    logic [2:0] crc;
    logic       ok;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[4];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   model_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: message is the top five bits; CRC follows the LFSR rule bit by bit.
  task automatic ref_model(input logic [7:0] cw, output logic [4:0] m,
                           output logic [2:0] c, output logic ok);
    logic [2:0] s;
    logic       b;
    s = 3'b000;
    for (int i = 7; i >= 0; i--) begin
      b = (i >= 3) ? cw[i] : 1'b0;
      s = {b ^ s[2] ^ s[0], s[2:1]};
    end
    m  = cw[7:3];
    c  = s;
    ok = (s == cw[2:0]);
  endtask

  task automatic tick(input logic e, input logic d);
    ena     = 1'b1;
    enable  = e;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    tick(1'b0, 1'b0);
    chk("idle_done", done, 0);
    chk("idle_msg", msg_out, 0);
  endtask

  task automatic send(input logic [7:0] cw);
    logic [4:0] m;
    logic [2:0] c;
    logic       ok;
    for (int i = 7; i >= 0; i--) begin
      tick(1'b1, cw[i]);
      if (i > 0) chk("early_done", done, 0);
    end
    ref_model(cw, m, c, ok);
    if (!ok && CNT_EN != 0 && model_err < 255) model_err++;
  endtask

  task automatic check_model(input string tag, input logic [7:0] cw);
    logic [4:0] m;
    logic [2:0] c;
    logic       ok;
    ref_model(cw, m, c, ok);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_msg"}, msg_out, m);
    chk({tag, "_crc"}, crc_calc, c);
    chk({tag, "_ok"}, crc_ok, ok);
    chk({tag, "_err"}, crc_err, !ok);
    chk({tag, "_ecnt"}, err_count, model_err);
  endtask

  initial begin
    logic [7:0] cw;
    vecs[0] = '{8'hB3, 5'b10110, 3'b011, 1'b1, 8'd0};
    vecs[1] = '{8'hF9, 5'b11111, 3'b001, 1'b1, 8'd0};
    vecs[2] = '{8'h00, 5'b00000, 3'b000, 1'b1, 8'd0};
    vecs[3] = '{8'hB2, 5'b10110, 3'b011, 1'b0, 8'(CNT_EN)};

    reset = 1'b1; ena = 1'b1; enable = 1'b0; data_in = 1'b0;
    #12;
    chk("rst_done", done, 0);
    chk("rst_msg", msg_out, 0);
    chk("rst_crc", crc_calc, 0);
    chk("rst_ok", crc_ok, 0);
    chk("rst_err", crc_err, 0);
    chk("rst_ecnt", err_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fixed vectors with spec-given expected values
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].cw);
      chk("vec_done", done, 1);
      chk("vec_msg", msg_out, vecs[v].msg);
      chk("vec_crc", crc_calc, vecs[v].crc);
      chk("vec_ok", crc_ok, vecs[v].ok);
      chk("vec_err", crc_err, !vecs[v].ok);
      chk("vec_ecnt", err_count, vecs[v].ecnt);
      if (v == 0) begin
        for (int k = 0; k < 5; k++) begin
          tick(1'b1, 1'($urandom));
          chk("hold_done", done, 1);
          chk("hold_msg", msg_out, 5'b10110);
          chk("hold_crc", crc_calc, 3'b011);
          chk("hold_ok", crc_ok, 1);
        end
      end
      idle_cycle();
    end

    // Abort after four bits, then a clean frame
    for (int i = 7; i >= 4; i--) begin
      tick(1'b1, vecs[0].cw[i]);
      chk("abort_done", done, 0);
    end
    idle_cycle();
    send(8'hB3);
    check_model("after_abort", 8'hB3);
    idle_cycle();

    // ena low for three cycles mid-codeword
    cw = 8'hB3;
    for (int i = 7; i >= 5; i--) tick(1'b1, cw[i]);
    for (int k = 0; k < 3; k++) begin
      ena = 1'b0; enable = 1'b1; data_in = 1'(k);
      @(posedge clk); #1;
      chk("stall_done", done, 0);
    end
    for (int i = 4; i >= 0; i--) tick(1'b1, cw[i]);
    check_model("stall", 8'hB3);
    chk("stall_msg_abs", msg_out, 5'b10110);
    idle_cycle();

    // Asynchronous reset after six bits
    for (int i = 7; i >= 2; i--) tick(1'b1, cw[i]);
    #2 reset = 1'b1;
    #1;
    chk("midrst_done", done, 0);
    chk("midrst_msg", msg_out, 0);
    chk("midrst_crc", crc_calc, 0);
    chk("midrst_ok", crc_ok, 0);
    chk("midrst_err", crc_err, 0);
    chk("midrst_ecnt", err_count, 0);
    model_err = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 1; i >= 0; i--) tick(1'b1, cw[i]);
    chk("midrst_nodone", done, 0);
    idle_cycle();

    // Random codewords against the model
    for (int r = 0; r < 40; r++) begin
      cw = 8'($urandom);
      send(cw);
      check_model("rand", cw);
      idle_cycle();
    end

    // Saturation of the failure count
    for (int r = 0; r < 260; r++) begin
      send(8'hB2);
      tick(1'b0, 1'b0);
    end
    chk("sat_model", err_count, model_err);
    chk("sat_abs", err_count, (CNT_EN != 0) ? 255 : 0);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
    chk("sat_hold", err_count, (CNT_EN != 0) ? 255 : 0);
    #2 reset = 1'b1;
    #1;
    chk("sat_rst", err_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
